// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a DIM x DIM systolic tile: clear, operand load, skew drain, result readout, done.
// Optional perf counters are compiled in when SYSTOLIC_SEQ_CTRL_PERF_EN is defined.
module systolic_seq_ctrl #(
    parameter int DIM         = 8,
    parameter int DRAIN_STEPS = 3*DIM-2,
    parameter int CNT_W       = $clog2(3*DIM)+1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   ab_valid,
    output logic                   ab_ready,
    output logic                   feed_en,
    output logic                   sa_en,
    output logic                   sa_clr,
    output logic                   c_valid,
    input  logic                   c_ready,
    output logic [$clog2(DIM)-1:0] c_row,
    output logic                   busy,
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    output logic [31:0]            perf_cycles,
    output logic [31:0]            perf_stalls,
`endif
    output logic                   done
);

    localparam int RW = $clog2(DIM);
    localparam logic [CNT_W-1:0] ROW_MAX   = CNT_W'(DIM);
    localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(DIM-1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DRAIN_STEPS-1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_DRAIN, S_READ, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] step_q, step_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        step_d   = step_q;
        ab_ready = 1'b0;
        feed_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                row_d   = '0;
                step_d  = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                ab_ready = 1'b1;
                feed_en  = ab_valid;
                if (ab_valid) begin
                    if (row_q < ROW_MAX) row_d = row_q + 1'b1;
                    if (row_q == LAST_ROW) begin
                        state_d = S_DRAIN;
                        step_d  = '0;
                    end
                end
            end
            S_DRAIN: begin
                feed_en = 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d = S_READ;
                    row_d   = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_READ: begin
                if (c_ready) begin
                    if (row_q == LAST_ROW) state_d = S_DONE;
                    else                   row_d   = row_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides everything: no beat accepted, no step issued, counters frozen.
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            row_d    = row_q;
            step_d   = step_q;
            ab_ready = 1'b0;
            feed_en  = 1'b0;
        end
    end

    assign sa_en   = feed_en;
    assign sa_clr  = (state_q == S_CLEAR);
    assign c_valid = (state_q == S_READ) && !abort;
    assign c_row   = (state_q == S_READ) ? row_q[RW-1:0] : '0;
    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);

`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (start && !abort) begin
                perf_cycles_q <= '0;
                perf_stalls_q <= '0;
            end
        end else if (!abort) begin
            perf_cycles_q <= perf_cycles_q + 32'd1;
            if ((state_q == S_LOAD && !ab_valid) || (state_q == S_READ && !c_ready))
                perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule
